// File: rtl/muldiv_pkg.sv
// Shared op encodings and FSM state type
// for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 iterative signed/unsigned multiply and divide
// with a start/busy/done handshake, abort and divzero flag.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t r_state;
  state_t w_next;

  logic               r_div;
  logic               r_qs;
  logic               r_rs;
  logic               r_dz;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic               r_busy;
  logic               r_done;
  logic               r_divzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_in_div;
  logic               w_in_sgn;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_dz;
  logic               w_accept;
  logic               w_step;
  logic               w_wr;
  logic               w_kill;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shf;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rm;

  always_comb begin
    w_in_div = 1'b0;
    w_in_sgn = 1'b0;
    unique case (op)
      OP_MULT:  w_in_sgn = 1'b1;
      OP_MULTU: w_in_sgn = 1'b0;
      OP_DIV: begin
        w_in_div = 1'b1;
        w_in_sgn = 1'b1;
      end
      OP_DIVU:  w_in_div = 1'b1;
      default:  w_in_div = 1'b0;
    endcase
  end

  assign w_sa    = w_in_sgn & op_a[WIDTH-1];
  assign w_sb    = w_in_sgn & op_b[WIDTH-1];
  assign w_abs_a = w_sa ? -op_a : op_a;
  assign w_abs_b = w_sb ? -op_b : op_b;
  assign w_dz    = w_in_div & (op_b == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = w_dz ? DONE : RUN;
      RUN: begin
        if (abort)                    w_next = IDLE;
        else if (r_cnt == CNT_W'(1)) w_next = FIX;
      end
      FIX:     w_next = abort ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) & start;
    w_step   = (r_state == RUN);
    w_wr     = (r_state == FIX) & ~abort;
    w_kill   = abort & ((r_state == RUN) | (r_state == FIX));
  end

  // Multiply adds r_m into the upper half; divide shifts the
  // dividend out of the lower half into the partial remainder.
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_shf  = {r_rem, r_acc[WIDTH-1]};
  assign w_diff = w_shf - {1'b0, r_m};
  assign w_qbit = ~w_diff[WIDTH];

  assign w_prod = r_qs ? -r_acc : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_quo  = r_qs ? -w_q : w_q;
  assign w_rm   = r_rs ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= 1'b0;
      r_qs  <= 1'b0;
      r_rs  <= 1'b0;
      r_dz  <= 1'b0;
      r_cnt <= '0;
      r_m   <= '0;
      r_acc <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_div <= w_in_div;
      r_qs  <= w_sa ^ w_sb;
      r_rs  <= w_sa;
      r_dz  <= w_dz;
      r_cnt <= w_dz ? '0 : CNT_W'(WIDTH);
      r_m   <= w_in_div ? w_abs_b : w_abs_a;
      r_acc <= {{WIDTH{1'b0}}, w_in_div ? w_abs_a : w_abs_b};
      r_rem <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_div) begin
        r_rem <= w_qbit ? w_diff[WIDTH-1:0] : w_shf[WIDTH-1:0];
        r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
      end else begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end
    end
  end

  // Handshake outputs lag the state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_busy    <= (r_state != IDLE) & ~w_kill;
      r_done    <= (r_state == DONE);
      r_divzero <= (r_state == DONE) & r_dz;
      if (w_wr) begin
        r_hi <= r_div ? w_rm : w_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign divzero = r_divzero;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit
// at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        abort = 1'b0;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  op_a8 = '0;
  logic [7:0]  op_b8 = '0;
  logic        abort8 = 1'b0;
  logic        busy8, done8, divzero8;
  logic [7:0]  hi8, lo8;

  int n_pass = 0;
  int n_tot  = 0;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .op_a(op_a), .op_b(op_b), .abort(abort),
    .busy(busy), .done(done), .divzero(divzero),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .op_a(op_a8), .op_b(op_b8), .abort(abort8),
    .busy(busy8), .done(done8), .divzero(divzero8),
    .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  // Launch one op and count edges until done (-1 on timeout).
  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output int          cyc,
    output int          bcnt,
    output logic        dz
  );
    @(negedge clk);
    op = o; op_a = x; op_b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = -1; bcnt = 0; dz = divzero;
    if (busy) bcnt++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      dz = dz | divzero;
      if (done) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tot++;
    if ({busy, done, divzero} !== 3'b000) begin
      $display("FAIL reset_flags got=%b want=000",
               {busy, done, divzero});
    end else n_pass++;
    n_tot++;
    if ({hi, lo} !== 64'h0) begin
      $display("FAIL reset_hilo got=%h want=0", {hi, lo});
    end else n_pass++;
  endtask

  task automatic test_mult();
    int c, b; logic z;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, c, b, z);
    n_tot++;
    if (c !== 34) $display("FAIL mult_lat got=%0d want=34", c);
    else n_pass++;
    n_tot++;
    if (b !== 34) $display("FAIL mult_busy got=%0d want=34", b);
    else n_pass++;
    n_tot++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL mult_neg got=%h want=ffffffffffffffeb",
               {hi, lo});
    else n_pass++;
    n_tot++;
    if (z !== 1'b0) $display("FAIL mult_dz got=%b want=0", z);
    else n_pass++;
    @(posedge clk); #1;
    n_tot++;
    if (busy !== 1'b0) $display("FAIL mult_busy_end got=%b want=0", busy);
    else n_pass++;
  endtask

  task automatic test_multu();
    int c, b; logic z;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, b, z);
    n_tot++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL multu_max got=%h want=fffffffe00000001", {hi, lo});
    else n_pass++;
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c, b, z);
    n_tot++;
    if ({hi, lo} !== 64'h0000_0000_0000_0001)
      $display("FAIL mult_m1m1 got=%h want=0000000000000001", {hi, lo});
    else n_pass++;
  endtask

  task automatic test_div();
    int c, b; logic z;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, c, b, z);
    n_tot++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
      $display("FAIL div_neg got=%h want=fffffffffffffffd", {hi, lo});
    else n_pass++;
    n_tot++;
    if (c !== 34) $display("FAIL div_lat got=%0d want=34", c);
    else n_pass++;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, b, z);
    n_tot++;
    if ({hi, lo} !== 64'h0000_0000_8000_0000)
      $display("FAIL div_min got=%h want=0000000080000000", {hi, lo});
    else n_pass++;
    run_op(OP_DIVU, 32'd100, 32'd7, c, b, z);
    n_tot++;
    if ({hi, lo} !== {32'd2, 32'd14})
      $display("FAIL divu got=%h want=000000020000000e", {hi, lo});
    else n_pass++;
    n_tot++;
    if (z !== 1'b0) $display("FAIL divu_dz got=%b want=0", z);
    else n_pass++;
  endtask

  task automatic test_divzero();
    int c, b; logic z;
    run_op(OP_DIV, 32'd5, 32'd0, c, b, z);
    n_tot++;
    if (c !== 1) $display("FAIL dz_lat got=%0d want=1", c);
    else n_pass++;
    n_tot++;
    if (divzero !== 1'b1) $display("FAIL dz_flag got=%b want=1", divzero);
    else n_pass++;
    n_tot++;
    if ({hi, lo} !== {32'd2, 32'd14})
      $display("FAIL dz_hold got=%h want=000000020000000e", {hi, lo});
    else n_pass++;
    @(posedge clk); #1;
    n_tot++;
    if ({done, divzero} !== 2'b00)
      $display("FAIL dz_pulse got=%b want=00", {done, divzero});
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int c;
    @(negedge clk);
    op = OP_MULT; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = OP_MULTU; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = -1;
    for (int n = 6; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        c = n;
        break;
      end
    end
    n_tot++;
    if (c !== 34) $display("FAIL ign_lat got=%0d want=34", c);
    else n_pass++;
    n_tot++;
    if ({hi, lo} !== {32'd0, 32'd42})
      $display("FAIL ign_res got=%h want=000000000000002a", {hi, lo});
    else n_pass++;
  endtask

  task automatic test_abort();
    int c, b; logic z; logic seen;
    @(negedge clk);
    op = OP_MULT; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_tot++;
    if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy);
    else n_pass++;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen = seen | done | busy;
    end
    n_tot++;
    if (seen !== 1'b0) $display("FAIL abort_done got=%b want=0", seen);
    else n_pass++;
    n_tot++;
    if ({hi, lo} !== {32'd0, 32'd42})
      $display("FAIL abort_hold got=%h want=000000000000002a", {hi, lo});
    else n_pass++;
    run_op(OP_MULTU, 32'd5, 32'd5, c, b, z);
    n_tot++;
    if ({c, lo} !== {32'd34, 32'd25})
      $display("FAIL abort_next got=%0d/%0d want=34/25", c, lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c, b; logic z;
    run_op(OP_MULTU, 32'd3, 32'd4, c, b, z);
    n_tot++;
    if (lo !== 32'd12) $display("FAIL b2b_first got=%0d want=12", lo);
    else n_pass++;
    run_op(OP_DIVU, 32'd50, 32'd5, c, b, z);
    n_tot++;
    if ({c, hi, lo} !== {32'd34, 32'd0, 32'd10})
      $display("FAIL b2b_second got=%0d/%0d/%0d want=34/0/10", c, hi, lo);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = OP_MULT; op_a = 32'd11; op_b = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    n_tot++;
    if ({busy, done, hi, lo} !== 66'h0)
      $display("FAIL async_rst got=%b/%b/%h/%h want=0/0/0/0",
               busy, done, hi, lo);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_width8();
    int c;
    @(negedge clk);
    op8 = OP_DIV; op_a8 = 8'h80; op_b8 = 8'h03; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    c = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin
        c = n;
        break;
      end
    end
    n_tot++;
    if (c !== 10) $display("FAIL w8_lat got=%0d want=10", c);
    else n_pass++;
    n_tot++;
    if ({hi8, lo8} !== 16'hFED6)
      $display("FAIL w8_div got=%h want=fed6", {hi8, lo8});
    else n_pass++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit: the next-generation replacement for the separate fixed-32-bit multiplier and divider blocks in the multicycle CPU datapath. It runs signed and unsigned multiply and divide on one shared radix-2 shift/add/subtract datapath with a start/busy/done handshake. Divide-by-zero is flagged so the control unit can vector to the divzero exception. It also supports abort, which the old blocks do not. Results drive the HI/LO registers through their existing write enables.

Parameters:
WIDTH, 32, operand width in bits; must be >= 2; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived localparam, not overridable.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
op_a  input  WIDTH  multiplicand or dividend (rs).
op_b  input  WIDTH  multiplier or divisor (rt).
abort  input  1  cancel the operation in flight; ignored in IDLE.
busy  output  1  high from the cycle after accept until done (inclusive).
done  output  1  one-cycle pulse when the operation ends.
divzero  output  1  one-cycle pulse coincident with done, for a DIV/DIVU with op_b == 0.
hi  output  WIDTH  upper product or remainder; registered.
lo  output  WIDTH  lower product or quotient; registered.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1:
  - Latch op.
  - Latch |op_a| and |op_b| for signed ops; latch raw values for unsigned ops.
  - Record the result signs: product sign = sign_a ^ sign_b; quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
  - If op is DIV/DIVU and op_b == 0, go to DONE with a divzero flag. Otherwise load counter=WIDTH and go to RUN.
- RUN: one iteration per cycle; counter decrements; leave for FIX when the counter reaches 0 after the step.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
- FIX: apply two's-complement negation per the recorded signs, write hi/lo, go to DONE.
- DONE: done=1 for exactly one cycle (divzero=1 as well if flagged), then IDLE. A new start is accepted on the cycle after DONE.
- Latency:
  - Normal ops: done rises exactly WIDTH+2 cycles after the start sample edge (1 accept + WIDTH RUN + 1 FIX), i.e. 34 cycles at WIDTH=32.
  - Divide by zero: done rises 1 cycle after accept.
- hi/lo update only in FIX and hold their value otherwise. Divzero, abort and ignored starts leave hi/lo unchanged.
- start while busy: ignored. No queuing; op/op_a/op_b changes during busy have no effect.
- abort in RUN or FIX: next state IDLE, busy drops next cycle, no done, no hi/lo write. abort in DONE: done still completes.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
  - MIN / -1 yields lo=MIN, hi=0 (wraps; no overflow flag).
- Signed multiply: full 2*WIDTH signed product, hi = upper WIDTH bits. Unsigned ops use magnitude arithmetic only.
- Reset asserted mid-operation: immediate return to the reset values above; the in-flight result is lost.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11;
  - state typedef {IDLE, RUN, FIX, DONE}.
- The control FSM opcode decoder imports the same op constants.
- No sub-module required; the datapath and FSM live in one module. The two's-complement conditional negate may be a function in muldiv_pkg.

Test Plan:
- MULT op_a=0xFFFFFFFD (-3), op_b=7 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 34 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- After a result hi=2, lo=14: DIV 5/0 -> done and divzero both high 1 cycle after accept; hi=2, lo=14 unchanged; divzero low on all other ops.
- start pulsed at cycle 5 of a running MULT with different operands -> ignored; the original result is returned at cycle 34. abort at cycle 10 -> no done, hi/lo unchanged, next start accepted.
- reset driven low asynchronously mid-RUN (between clock edges) -> busy, done, hi and lo go to 0 immediately. Rerun at WIDTH=8 with DIV -128/3 -> lo=0xD6, hi=0xFE, done 10 cycles after start.
